// File: rtl/display_select_ctrl.sv
// display_select_ctrl: debug display front end.
// Synchronises and debounces three active-low pushbuttons. It keeps a
// wrap-around source index for the display mux and a display on/off mode.
// Optional feature: define AUTO_SCAN_EN to add a SCAN mode. In SCAN the
// index advances automatically every SCAN_CYCLES cycles.
module display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_SOURCES     = 8,
  parameter int SCAN_CYCLES     = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Key_Next_n,
  input  logic       Key_Prev_n,
  input  logic       Key_Show_n,
  output logic [4:0] Display_Select,
  output logic       Display_Enable,
  output logic       Select_Changed
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] SEL_LAST = 5'(NUM_SOURCES - 1);

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_SCAN} mode_t;

  // Key bit order: 0 = next, 1 = prev, 2 = show.
  logic [2:0] key_raw_n;
  logic [2:0] press_ev;
  logic       next_ev, prev_ev, show_ev;

  assign key_raw_n = {Key_Show_n, Key_Prev_n, Key_Next_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic            sync1_reg, sync2_reg, stable_reg, press_reg;
      logic [DB_W-1:0] cnt_reg;

      // Two-flop synchroniser, then accept a level only after DEBOUNCE_CYCLES
      // consecutive cycles that differ from the debounced state.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          stable_reg <= 1'b1;
          press_reg  <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= key_raw_n[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            // Only the released->pressed transition is an event.
            press_reg  <= stable_reg;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign press_ev[gi] = press_reg;
    end
  endgenerate

  assign next_ev = press_ev[0];
  assign prev_ev = press_ev[1];
  assign show_ev = press_ev[2];

  logic [4:0] sel_reg, sel_next, sel_inc, sel_dec;
  mode_t      mode_reg;
  logic       enable_reg;
  logic       changed_reg;
  logic       scan_tick;

  assign sel_inc = (sel_reg == SEL_LAST) ? 5'd0 : sel_reg + 5'd1;
  assign sel_dec = (sel_reg == 5'd0) ? SEL_LAST : sel_reg - 5'd1;

`ifdef AUTO_SCAN_EN
  localparam int SC_W = $clog2(SCAN_CYCLES > 1 ? SCAN_CYCLES : 2);
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_CYCLES - 1);

  logic [SC_W-1:0] timer_reg;

  // A manual step in the same cycle wins over the automatic step.
  assign scan_tick = (mode_reg == MODE_SCAN) && !next_ev && !prev_ev &&
                     (timer_reg == SCAN_LAST);

  // Dwell timer: runs only in SCAN. It restarts on any step or mode change.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      timer_reg <= '0;
    end else if ((mode_reg != MODE_SCAN) || show_ev || next_ev || prev_ev || scan_tick) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + SC_W'(1);
    end
  end
`else
  assign scan_tick = 1'b0;

  // The dwell length has no meaning without the scan state.
  if (SCAN_CYCLES < 1) begin : g_scan_unused
  end
`endif

  // Next-index selection. Simultaneous Next and Prev cancel out.
  always_comb begin
    sel_next = sel_reg;
    if (next_ev && !prev_ev) begin
      sel_next = sel_inc;
    end else if (prev_ev && !next_ev) begin
      sel_next = sel_dec;
    end else if (scan_tick) begin
      sel_next = sel_inc;
    end
  end

  // Index register, change pulse and display-mode FSM with registered enable.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_reg     <= 5'd0;
      changed_reg <= 1'b0;
      mode_reg    <= MODE_OFF;
      enable_reg  <= 1'b1;
    end else begin
      sel_reg     <= sel_next;
      changed_reg <= (sel_next != sel_reg);
      if (show_ev) begin
        case (mode_reg)
          MODE_OFF: begin
            mode_reg   <= MODE_ON;
            enable_reg <= 1'b0;
          end
`ifdef AUTO_SCAN_EN
          MODE_ON: begin
            mode_reg   <= MODE_SCAN;
            enable_reg <= 1'b0;
          end
`endif
          default: begin
            mode_reg   <= MODE_OFF;
            enable_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Display_Select = sel_reg;
  assign Display_Enable = enable_reg;
  assign Select_Changed = changed_reg;

endmodule

// File: tb/tb_display_select_ctrl.sv
// Testbench for display_select_ctrl: directed steps plus random key presses.
// Outputs are compared every cycle against a behavioural model.
module tb_display_select_ctrl;

  localparam int D  = 4;
  localparam int N  = 8;
  localparam int SC = 10;
`ifdef AUTO_SCAN_EN
  localparam int MODES = 3;
`else
  localparam int MODES = 2;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Key_Next_n = 1'b1;
  logic       Key_Prev_n = 1'b1;
  logic       Key_Show_n = 1'b1;
  logic [4:0] Display_Select;
  logic       Display_Enable;
  logic       Select_Changed;

  int checks = 0;
  int failures = 0;
  int chg_count = 0;

  display_select_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .NUM_SOURCES(N),
    .SCAN_CYCLES(SC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Key_Next_n(Key_Next_n),
    .Key_Prev_n(Key_Prev_n),
    .Key_Show_n(Key_Show_n),
    .Display_Select(Display_Select),
    .Display_Enable(Display_Enable),
    .Select_Changed(Select_Changed)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model. Each key's level is delayed two samples. A key is
  // accepted once its last D delayed samples all differ from the accepted level.
  // A press changes the outputs one cycle later.
  logic [1:0]   m_sh [3];
  logic         m_stable [3];
  logic [D-1:0] m_win [3];
  int           m_fill [3];
  logic         m_pend [3];
  int           m_sel, m_mode, m_timer;
  logic         m_en, m_chg;

  task automatic model_step();
    logic [2:0] raw;
    logic       s, f_next, f_prev, f_show;
    int         old_sel;
    raw = {Key_Show_n, Key_Prev_n, Key_Next_n};
    if (Reset) begin
      for (int k = 0; k < 3; k++) begin
        m_sh[k] = 2'b11; m_stable[k] = 1'b1; m_win[k] = '0; m_fill[k] = 0; m_pend[k] = 1'b0;
      end
      m_sel = 0; m_mode = 0; m_timer = 0; m_en = 1'b1; m_chg = 1'b0;
    end else begin
      old_sel = m_sel;
      f_next = m_pend[0]; f_prev = m_pend[1]; f_show = m_pend[2];
      if (f_next && !f_prev) m_sel = (m_sel + 1) % N;
      else if (f_prev && !f_next) m_sel = (m_sel + N - 1) % N;
`ifdef AUTO_SCAN_EN
      if (m_mode == 2) begin
        if (f_next || f_prev) m_timer = 0;
        else if (m_timer == SC - 1) begin m_sel = (m_sel + 1) % N; m_timer = 0; end
        else m_timer++;
      end
`endif
      if (f_show) m_mode = (m_mode + 1) % MODES;
      if (m_mode != 2) m_timer = 0;
      m_en  = (m_mode == 0);
      m_chg = (m_sel != old_sel);
      for (int k = 0; k < 3; k++) begin
        s = m_sh[k][1];
        m_win[k] = {m_win[k][D-2:0], s};
        if (m_fill[k] < D) m_fill[k]++;
        m_pend[k] = 1'b0;
        if (m_fill[k] == D && m_win[k] == {D{~m_stable[k]}}) begin
          m_pend[k]   = m_stable[k];
          m_stable[k] = s;
        end
        m_sh[k] = {m_sh[k][0], raw[k]};
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    checks++;
    assert (Display_Select === 5'(m_sel)) else begin
      failures++; $error("FAIL %s select got=%0d exp=%0d", tag, Display_Select, m_sel);
    end
    checks++;
    assert (Display_Enable === m_en) else begin
      failures++; $error("FAIL %s enable got=%b exp=%b", tag, Display_Enable, m_en);
    end
    checks++;
    assert (Select_Changed === m_chg) else begin
      failures++; $error("FAIL %s changed got=%b exp=%b", tag, Select_Changed, m_chg);
    end
    if (Select_Changed === 1'b1) chg_count++;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
    $display("step %s: got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic set_key(input int key, input logic lvl);
    case (key)
      0: Key_Next_n = lvl;
      1: Key_Prev_n = lvl;
      default: Key_Show_n = lvl;
    endcase
  endtask

  task automatic press(input int key, input int lo, input int hi);
    set_key(key, 1'b0);
    repeat (lo) tick("press_lo");
    set_key(key, 1'b1);
    repeat (hi) tick("press_hi");
  endtask

  task automatic wait_change(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick(tag);
      n++;
    end while (Select_Changed !== 1'b1 && n < budget);
    checks++;
    assert (Select_Changed === 1'b1) else begin
      failures++; $error("FAIL %s no select change within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int n;
    int k;
    int lo;
    int hi;

    // 1. Reset with Next and Show held low, then one event of each.
    Reset = 1'b1; Key_Next_n = 1'b0; Key_Show_n = 1'b0;
    repeat (3) begin
      tick("t1_reset");
      expect_val("t1_rst_sel", Display_Select, 0);
      expect_val("t1_rst_en", Display_Enable, 1);
      expect_val("t1_rst_chg", Select_Changed, 0);
    end
    Reset = 1'b0;
    repeat (12) tick("t1_hold");
    expect_val("t1_sel", Display_Select, 1);
    expect_val("t1_en", Display_Enable, 0);
    Key_Next_n = 1'b1; Key_Show_n = 1'b1;
    repeat (10) tick("t1_rel");

    // 2. Eight clean Next presses wrap all the way round.
    chg_count = 0;
    for (int i = 1; i <= 8; i++) begin
      press(0, 10, 10);
      expect_val("t2_sel", Display_Select, (1 + i) % N);
    end
    expect_val("t2_pulses", chg_count, 8);

    // 3. Bouncing Next, then held low: one step, 7 cycles after the last edge.
    for (int i = 0; i < 10; i++) begin
      Key_Next_n = ~Key_Next_n;
      repeat (2) tick("t3_bounce");
    end
    expect_val("t3_no_step", Display_Select, 1);
    Key_Next_n = 1'b0;
    repeat (6) tick("t3_wait");
    expect_val("t3_before", Display_Select, 1);
    tick("t3_edge");
    expect_val("t3_after", Display_Select, 2);
    expect_val("t3_pulse", Select_Changed, 1);
    Key_Next_n = 1'b1;
    repeat (10) tick("t3_rel");

    // 4. Prev wraps below 0; simultaneous Next+Prev leave the index alone.
    press(1, 10, 10);
    press(1, 10, 10);
    expect_val("t4_zero", Display_Select, 0);
    press(1, 10, 10);
    expect_val("t4_wrap", Display_Select, N - 1);
    chg_count = 0;
    Key_Next_n = 1'b0; Key_Prev_n = 1'b0;
    repeat (12) tick("t4_both");
    Key_Next_n = 1'b1; Key_Prev_n = 1'b1;
    repeat (10) tick("t4_rel");
    expect_val("t4_both_sel", Display_Select, N - 1);
    expect_val("t4_both_pulses", chg_count, 0);

    // Random key activity, including short bounces and overlapping keys.
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 2);
      lo = $urandom_range(1, 12);
      hi = $urandom_range(1, 12);
      set_key(k, 1'b0);
      if ($urandom_range(0, 3) == 0) set_key((k + 1) % 3, 1'b0);
      repeat (lo) tick("rand_lo");
      Key_Next_n = 1'b1; Key_Prev_n = 1'b1; Key_Show_n = 1'b1;
      repeat (hi) tick("rand_hi");
    end
    repeat (12) tick("rand_settle");

    // 5. Show steps the mode; reset mid-debounce discards a pending Next.
    Reset = 1'b1;
    repeat (2) tick("t5_reset");
    Reset = 1'b0;
    press(2, 10, 10);
    expect_val("t5_show1", Display_Enable, 0);
    press(2, 10, 10);
    expect_val("t5_show2", Display_Enable, ((2 % MODES) == 0) ? 1 : 0);
    press(2, 10, 10);
    expect_val("t5_show3", Display_Enable, ((3 % MODES) == 0) ? 1 : 0);
    Key_Next_n = 1'b0;
    repeat (3) tick("t5_mid");
    Reset = 1'b1; Key_Next_n = 1'b1;
    repeat (2) tick("t5_reset2");
    Reset = 1'b0;
    chg_count = 0;
    repeat (10) tick("t5_after");
    expect_val("t5_sel", Display_Select, 0);
    expect_val("t5_en", Display_Enable, 1);
    expect_val("t5_pulses", chg_count, 0);

`ifdef AUTO_SCAN_EN
    // 6. Auto-scan steps every SC cycles; a manual step restarts the dwell.
    press(1, 10, 10);
    press(1, 10, 10);
    expect_val("t6_start", Display_Select, 6);
    press(2, 10, 10);
    Key_Show_n = 1'b0;
    repeat (8) tick("t6_show");
    Key_Show_n = 1'b1;
    wait_change("t6_step1", 20, n);
    expect_val("t6_sel7", Display_Select, 7);
    wait_change("t6_step2", 20, n);
    expect_val("t6_dwell", n, SC);
    expect_val("t6_sel0", Display_Select, 0);
    repeat (3) tick("t6_pre");
    Key_Next_n = 1'b0;
    wait_change("t6_manual", 12, n);
    expect_val("t6_manual_lat", n, 7);
    expect_val("t6_manual_sel", Display_Select, 1);
    Key_Next_n = 1'b1;
    wait_change("t6_step3", 20, n);
    expect_val("t6_dwell2", n, SC);
    expect_val("t6_sel2", Display_Select, 2);
    Key_Show_n = 1'b0;
    repeat (8) tick("t6_off");
    Key_Show_n = 1'b1;
    expect_val("t6_off_en", Display_Enable, 1);
    chg_count = 0;
    repeat (25) tick("t6_idle");
    expect_val("t6_stopped", chg_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
